bcd_conv_sched: RTL and testbench
=================================

# bcd_conv_sched

Round-robin scheduler sharing one 8-bit binary-to-BCD converter among `N` requesters (display fields: temperature, counters, menu values) in the Nokia 5110 display path. It arbitrates requests and drives the converter's 4-phase start/done handshake. It saturates out-of-range inputs and returns a two-digit result plus a one-cycle acknowledge to the winning requester. The converter stays a separate instance; this block owns only its control ports.

## Interface
- `N`, 4: number of requesters, 2..8
- `SAT_MAX`, 99: largest value passed to the converter unclamped
- `clk`  in  1  system clock; all logic on rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `req`  in  `N`  per-requester request level
- `value`  in  `N*8`  requester *i* value in bits `[8i+7:8i]`
- `ack`  out  `N`  one-hot, one-cycle completion pulse
- `res_tens`  out  4  BCD tens digit, valid when `ack` != 0
- `res_ones`  out  4  BCD ones digit, valid when `ack` != 0
- `res_ovf`  out  1  input exceeded `SAT_MAX` and was clamped, valid with `ack`
- `busy`  out  1  conversion in progress (state != IDLE)
- `cv_start`  out  1  converter start
- `cv_in`  out  8  converter operand
- `cv_done`  in  1  converter done
- `cv_tens`  in  4  converter tens digit
- `cv_ones`  in  4  converter ones digit

## Operation
- **Requester contract:**
  - Hold `req[i]` high and `value[i]` stable until `ack[i]`.
  - Drop `req[i]` in the cycle after `ack[i]`. If `req[i]` is still high, it is a new request.
- **Converter contract (4-phase):**
  - Raise `cv_start` with `cv_in` valid; hold both until `cv_done`=1.
  - Drop `cv_start`, then wait for `cv_done`=0 before the next start.
- **FSM states:**
  - IDLE:
    - If `req` != 0, grant the round-robin winner (see Arbitration).
    - Latch its index and value.
    - Register `cv_in` = min(value, `SAT_MAX`) and `cv_start`=1 in the same edge.
    - Record `ovf` = (value > `SAT_MAX`).
    - Go to ISSUE.
  - ISSUE: hold `cv_start`. On `cv_done`=1, capture `cv_tens`/`cv_ones`, clear `cv_start`, go to RELEASE.
  - RELEASE: wait for `cv_done`=0, then go to ACK.
  - ACK:
    - Pulse `ack[idx]` for one cycle, with `res_*` driven from the captured registers.
    - Advance the pointer to idx+1 mod `N`.
    - Go to IDLE.
- **Arbitration:**
  - Rotating priority starting at the pointer; the pointer resets to 0.
  - The served requester becomes lowest priority.
  - All `N` asserted continuously → service order 0,1,2,…,N-1,0.
- `req` is sampled only in IDLE. Changes during ISSUE, RELEASE or ACK do not alter the current grant.
- A requester dropping `req` mid-conversion: the conversion completes and the ack still pulses (the requester ignores it).
- `res_tens`/`res_ones`/`res_ovf` hold their last captured value between acks.
- No assumption on converter latency; the block waits on `cv_done` indefinitely.

## Timing
- **Reset values:**
  - `ack`=0, `res_tens`=0, `res_ones`=0, `res_ovf`=0.
  - `busy`=0, `cv_start`=0, `cv_in`=0.
  - State IDLE, pointer 0.
- **Cycle sequence, request present at IDLE edge T:**
  - `cv_start`=1 from T+1.
  - `cv_done` seen high at edge D → `cv_start`=0 from D+1.
  - `cv_done` seen low at edge E → `ack` high for cycle E+1 only.
  - Next grant is possible at E+2.
- **Latency:** controller overhead is 3 cycles beyond converter latency. Total request-to-ack is converter latency + 3.
- `busy` is high from T+1 through the ACK cycle inclusive.
- **Reset mid-operation:** all outputs return to reset values immediately and asynchronously. The converter shares `nrst`, so both restart clean and no ack is issued for the aborted request.
- **Unexpected `cv_done`=1 while IDLE:** ignored. The next start waits until `cv_done`=0.

## Structure
- Package `bcd_sched_pkg`:
  - State enum `{IDLE, ISSUE, RELEASE, ACK}`.
  - Constant `BCD_W`=4 and `VAL_W`=8.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req`, `ptr`.
  - Output: one-hot `gnt` and encoded `idx`.
  - Combinational.

## Test plan
- Single request: `req`=0001, `value[0]`=8'd42 → one ack on `ack`=0001, `res_tens`=4, `res_ones`=2, `res_ovf`=0.
- Saturation: `req[2]` with value 8'd200 → `cv_in`=99, `res_tens`=9, `res_ones`=9, `res_ovf`=1.
- Fairness: `req`=1111 held, values 7/58/90/13 → acks in order 0,1,2,3,0; each result correct; no starvation.
- Handshake order: converter model delays `cv_done` fall by 5 cycles → `ack` 1 cycle after the fall; no `cv_start` while `cv_done`=1.
- Reset mid-conversion: assert `nrst`=0 while in ISSUE → all outputs 0 instantly. After release, `req[1]`=8'd0 → `res_tens`=0, `res_ones`=0.
- Late drop: `req[3]` deasserted during ISSUE with value 8'd99 → ack still pulses, result 9/9; pointer moves to 0.

Source files
------------

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_sched_pkg;

    localparam int BCD_W = 4;
    localparam int VAL_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        ACK
    } state_t;

    // Clamp a requester value to the largest value the converter accepts.
    function automatic logic [VAL_W-1:0] sat_val(input logic [VAL_W-1:0] v,
                                                 input int unsigned     max_v);
        return (32'(v) > max_v) ? VAL_W'(max_v) : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or after ptr wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] pos;

    // Walk the requesters starting at ptr and take the first one asserted.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shares one binary-to-BCD converter among N requesters, round-robin.
// Latency: converter latency + 3 cycles from grant to one-cycle ack.
// Backpressure: requests wait in IDLE; the converter is waited on indefinitely.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int SAT_MAX = 99
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [N-1:0]       req,
    input  logic [N*VAL_W-1:0] value,
    output logic [N-1:0]       ack,
    output logic [BCD_W-1:0]   res_tens,
    output logic [BCD_W-1:0]   res_ones,
    output logic               res_ovf,
    output logic               busy,
    output logic               cv_start,
    output logic [VAL_W-1:0]   cv_in,
    input  logic               cv_done,
    input  logic [BCD_W-1:0]   cv_tens,
    input  logic [BCD_W-1:0]   cv_ones
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    cur_idx;
    logic [N-1:0]     cur_gnt;
    logic             ovf_r;
    logic [N-1:0]     win_gnt;
    logic [IW-1:0]    win_idx;
    logic [VAL_W-1:0] win_val;
    logic             grant;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    // A stray cv_done while idle holds off the next start until it clears.
    assign grant = (state == IDLE) && (|req) && !cv_done;
    assign busy  = (state != IDLE);

    // Operand of the current winner.
    always_comb begin
        win_val = value[win_idx*VAL_W +: VAL_W];
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: walk the 4-phase converter handshake, then ack.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)    state_nxt = ISSUE;
            ISSUE:   if (cv_done)  state_nxt = RELEASE;
            RELEASE: if (!cv_done) state_nxt = ACK;
            ACK:                   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Grant latch, converter drive, result capture, ack pulse and pointer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr      <= '0;
            cur_idx  <= '0;
            cur_gnt  <= '0;
            ovf_r    <= 1'b0;
            cv_start <= 1'b0;
            cv_in    <= '0;
            res_tens <= '0;
            res_ones <= '0;
            res_ovf  <= 1'b0;
            ack      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_gnt  <= win_gnt;
                        cur_idx  <= win_idx;
                        cv_in    <= sat_val(win_val, SAT_MAX);
                        ovf_r    <= int'(win_val) > SAT_MAX;
                        cv_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cv_done) begin
                        res_tens <= cv_tens;
                        res_ones <= cv_ones;
                        res_ovf  <= ovf_r;
                        cv_start <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!cv_done) ack <= cur_gnt;
                end
                ACK: begin
                    ptr <= (cur_idx == IW'(N - 1)) ? '0 : cur_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: converter model, scoreboard, directed and random stimulus.
// Latency: n/a.
// Backpressure: converter model latencies are varied at run time.
module tb_bcd_conv_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req;
    logic [N*8-1:0] value;
    logic [N-1:0]   ack;
    logic [3:0]     res_tens, res_ones;
    logic           res_ovf, busy, cv_start;
    logic [7:0]     cv_in;
    logic           cv_done;
    logic [3:0]     cv_tens, cv_ones;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_conv_sched #(.N(N), .SAT_MAX(99)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .value    (value),
        .ack      (ack),
        .res_tens (res_tens),
        .res_ones (res_ones),
        .res_ovf  (res_ovf),
        .busy     (busy),
        .cv_start (cv_start),
        .cv_in    (cv_in),
        .cv_done  (cv_done),
        .cv_tens  (cv_tens),
        .cv_ones  (cv_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Converter model: 4-phase start/done with adjustable latencies.
    logic       done_m;
    logic [3:0] t_m, o_m;
    int         cnt;
    int         lat = 2;
    int         fall = 1;
    logic       stray = 1'b0;

    assign cv_done = done_m | stray;
    assign cv_tens = t_m;
    assign cv_ones = o_m;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done_m <= 1'b0; cnt <= 0; t_m <= 4'd0; o_m <= 4'd0;
        end else if (!done_m) begin
            if (cv_start) begin
                if (cnt >= lat) begin
                    done_m <= 1'b1;
                    t_m    <= 4'(cv_in / 10);
                    o_m    <= 4'(cv_in % 10);
                    cnt    <= 0;
                end else cnt <= cnt + 1;
            end else cnt <= 0;
        end else if (!cv_start) begin
            if (cnt >= fall) begin
                done_m <= 1'b0; cnt <= 0;
            end else cnt <= cnt + 1;
        end
    end

    // Reference model: rotating priority from the pointer, clamp to 99, split digits.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    typedef struct { int idx; int tens; int ones; int ovf; } exp_t;
    exp_t           exp_q[$];
    exp_t           sb_e;
    int             mptr = 0;
    int             sb_w, sb_v, sb_c;
    int             viol = 0;
    logic [N-1:0]   req_s;
    logic [N*8-1:0] val_s;
    logic           prev_start = 1'b0;
    logic [7:0]     prev_in = 8'd0;

    always @(posedge clk) begin
        req_s <= req;
        val_s <= value;
    end

    always @(negedge clk) begin
        if (!nrst) begin
            exp_q.delete();
            mptr       = 0;
            prev_start = 1'b0;
        end else begin
            if (cv_start && !prev_start) begin
                if (cv_done) viol++;
                sb_w = pick(req_s, mptr);
                check("sb_grant_valid", int'(sb_w >= 0), 1);
                if (sb_w >= 0) begin
                    sb_v = int'(val_s[8*sb_w +: 8]);
                    sb_c = (sb_v > 99) ? 99 : sb_v;
                    check("sb_cv_in", int'(cv_in), sb_c);
                    exp_q.push_back('{sb_w, sb_c / 10, sb_c % 10, int'(sb_v > 99)});
                end
            end
            if (cv_start && prev_start && cv_in !== prev_in) viol++;
            if (ack != '0) begin
                check("sb_ack_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    sb_e = exp_q.pop_front();
                    check("sb_ack", int'(ack), 1 << sb_e.idx);
                    check("sb_tens", int'(res_tens), sb_e.tens);
                    check("sb_ones", int'(res_ones), sb_e.ones);
                    check("sb_ovf", int'(res_ovf), sb_e.ovf);
                    mptr = (sb_e.idx + 1) % N;
                end
            end
            prev_start = cv_start;
            prev_in    = cv_in;
        end
    end

    task automatic raise(input int i, input logic [7:0] v);
        @(posedge clk); #1;
        value[8*i +: 8] = v;
        req[i] = 1'b1;
    endtask

    task automatic drop(input int i);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] a,
                            output logic [3:0] t, output logic [3:0] o, output logic v);
        a = '0; t = '0; o = '0; v = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                a = ack; t = res_tens; o = res_ones; v = res_ovf;
                break;
            end
        end
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cv_start) break;
        end
        check("start_seen", int'(cv_start), 1);
    endtask

    task automatic expect_ack(input string nm, input int ei, input int et, input int eo, input int ev);
        logic [N-1:0] a;
        logic [3:0]   t, o;
        logic         v;
        wait_ack(80, a, t, o, v);
        check({nm, "_ack"}, int'(a), 1 << ei);
        check({nm, "_tens"}, int'(t), et);
        check({nm, "_ones"}, int'(o), eo);
        check({nm, "_ovf"}, int'(v), ev);
    endtask

    typedef struct { int idx; int val; int tens; int ones; int ovf; } vec_t;
    vec_t tbl[8];
    int   fv[4];
    int   ord[5];
    int   cyc, fall_c, ack_c;
    logic seen_hi;
    logic [N-1:0] ha;

    initial begin
        tbl[0] = '{0, 42, 4, 2, 0};
        tbl[1] = '{2, 200, 9, 9, 1};
        tbl[2] = '{1, 0, 0, 0, 0};
        tbl[3] = '{3, 99, 9, 9, 0};
        tbl[4] = '{0, 100, 9, 9, 1};
        tbl[5] = '{1, 255, 9, 9, 1};
        tbl[6] = '{2, 9, 0, 9, 0};
        tbl[7] = '{3, 10, 1, 0, 0};
        fv  = '{7, 58, 90, 13};
        ord = '{0, 1, 2, 3, 0};

        req = '0; value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", int'(ack), 0);
        check("rst_tens", int'(res_tens), 0);
        check("rst_ones", int'(res_ones), 0);
        check("rst_ovf", int'(res_ovf), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(cv_start), 0);
        check("rst_cv_in", int'(cv_in), 0);
        nrst = 1'b1;

        // Fairness: all four held, service order from pointer 0.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) value[8*i +: 8] = 8'(fv[i]);
        req = 4'hF;
        for (int k = 0; k < 5; k++)
            expect_ack("fair", ord[k], fv[ord[k]] / 10, fv[ord[k]] % 10, 0);
        @(posedge clk); #1;
        req = '0;

        // Single-request vectors, including saturation boundaries.
        for (int k = 0; k < 8; k++) begin
            raise(tbl[k].idx, 8'(tbl[k].val));
            expect_ack("tbl", tbl[k].idx, tbl[k].tens, tbl[k].ones, tbl[k].ovf);
            drop(tbl[k].idx);
        end

        // Slow done fall: ack exactly one cycle after cv_done falls.
        lat = 2; fall = 5;
        raise(1, 8'd37);
        fall_c = -100; ack_c = 0; seen_hi = 1'b0; ha = '0;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (cv_done) seen_hi = 1'b1;
            if (seen_hi && !cv_done && fall_c < 0) fall_c = cyc;
            if (ack != '0) begin
                ack_c = cyc; ha = ack;
                break;
            end
        end
        check("hs_fall_to_ack", ack_c - fall_c, 1);
        check("hs_ack", int'(ha), 2);
        check("hs_digits", int'({res_tens, res_ones}), 8'h37);
        drop(1);
        fall = 1;

        // Late drop: request withdrawn mid-conversion still completes.
        lat = 4;
        raise(3, 8'd99);
        wait_start(40);
        @(posedge clk); #1;
        req[3] = 1'b0;
        check("late_busy", int'(busy), 1);
        expect_ack("late", 3, 9, 9, 0);
        @(posedge clk); #1;
        value[15:8] = 8'd21; value[31:24] = 8'd64;
        req = 4'b1010;
        expect_ack("ptr_wrap", 1, 2, 1, 0);
        drop(1);
        expect_ack("ptr_next", 3, 6, 4, 0);
        drop(3);

        // Stray done while idle holds off the start.
        @(posedge clk); #1;
        stray = 1'b1;
        value[7:0] = 8'd5;
        req[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_no_start", int'(cv_start), 0);
        check("stray_idle", int'(busy), 0);
        @(posedge clk); #1;
        stray = 1'b0;
        expect_ack("stray", 0, 0, 5, 0);
        drop(0);

        // Saturated result in the registers, then reset mid-conversion.
        raise(2, 8'd250);
        expect_ack("pre_rst", 2, 9, 9, 1);
        drop(2);
        lat = 8;
        raise(2, 8'd50);
        wait_start(40);
        repeat (2) @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("mrst_ack", int'(ack), 0);
        check("mrst_tens", int'(res_tens), 0);
        check("mrst_ones", int'(res_ones), 0);
        check("mrst_ovf", int'(res_ovf), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_start", int'(cv_start), 0);
        check("mrst_cv_in", int'(cv_in), 0);
        @(posedge clk); #1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        lat = 2;
        raise(1, 8'd0);
        expect_ack("post_rst", 1, 0, 0, 0);
        drop(1);

        // Random traffic checked by the scoreboard.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    value[8*i +: 8] = 8'($urandom_range(0, 255));
                    req[i] = 1'b1;
                end
            end
            if (!busy) begin
                lat  = $urandom_range(0, 4);
                fall = $urandom_range(0, 3);
            end
        end
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (req[i] && ack[i]) req[i] = 1'b0;
            if (req == '0 && !busy) break;
        end
        check("drain", int'(req == '0 && !busy), 1);
        repeat (3) @(negedge clk);
        check("protocol_viol", viol, 0);
        check("sb_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
